// File: rtl/pixel_readout_if.sv
// Pixel word stream leaving the readout: one word per column, valid/ready flow control.
interface pixel_readout_if #(
    parameter int PIXEL_ARRAY_WIDTH  = 4,
    parameter int PIXEL_ARRAY_HEIGHT = 4
);
    localparam int ROW_W = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int COL_W = $clog2(PIXEL_ARRAY_WIDTH);

    logic [7:0]       out_data;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, out_row, out_col, out_valid, input out_ready);
    modport slave  (input out_data, out_row, out_col, out_valid, output out_ready);
endinterface

// File: rtl/pixel_readout.sv
// Row readout receiver: time-stamps each column's first comparator trip against the
// digital ramp, then streams the row out in column order.
module pixel_readout #(
    parameter int PIXEL_ARRAY_WIDTH  = 4,
    parameter int PIXEL_ARRAY_HEIGHT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0] p_row_select,
    input  logic [7:0]                    p_dRamp,
    input  logic [PIXEL_ARRAY_WIDTH-1:0]  p_cmp,
    pixel_readout_if.master               out_if,
    output logic                          frame_done,
    output logic                          overrun
);
    localparam int W     = PIXEL_ARRAY_WIDTH;
    localparam int H     = PIXEL_ARRAY_HEIGHT;
    localparam int ROW_W = $clog2(H);
    localparam int COL_W = $clog2(W);

    localparam logic [H-1:0]     SEL_ONE  = H'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DRAIN} state_t;

    state_t           state;
    logic             sel_seen;
    logic [H-1:0]     row_onehot;
    logic [ROW_W-1:0] row_idx;
    logic [7:0]       words [W];
    logic [W-1:0]     latched;

    logic             sel_nonzero;
    logic             sel_onehot;
    logic [ROW_W-1:0] sel_idx;

    assign sel_nonzero = |p_row_select;
    assign sel_onehot  = sel_nonzero && ((p_row_select & (p_row_select - SEL_ONE)) == '0);

    always_comb begin
        sel_idx = '0;
        for (int r = 0; r < H; r++) begin
            if (p_row_select[r]) sel_idx = ROW_W'(r);
        end
    end

    // sel_seen keeps a select held across rows from being mistaken for a new row start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            sel_seen         <= 1'b0;
            row_onehot       <= '0;
            row_idx          <= '0;
            latched          <= '0;
            for (int c = 0; c < W; c++) words[c] <= 8'h00;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= 8'h00;
            out_if.out_row   <= '0;
            out_if.out_col   <= '0;
            frame_done       <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            sel_seen   <= sel_nonzero;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sel_seen && sel_nonzero) begin
                        if (sel_onehot) begin
                            row_onehot <= p_row_select;
                            row_idx    <= sel_idx;
                            latched    <= p_cmp;
                            for (int c = 0; c < W; c++) begin
                                if (p_cmp[c]) words[c] <= p_dRamp;
                            end
                            state <= CONVERT;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    if (p_row_select != row_onehot) begin
                        // Columns that never tripped saturate at full scale.
                        for (int c = 0; c < W; c++) begin
                            if (!latched[c]) words[c] <= 8'hFF;
                        end
                        if (sel_nonzero) overrun <= 1'b1;
                        out_if.out_valid <= 1'b1;
                        out_if.out_col   <= '0;
                        out_if.out_row   <= row_idx;
                        out_if.out_data  <= latched[0] ? words[0] : 8'hFF;
                        state            <= DRAIN;
                    end else begin
                        for (int c = 0; c < W; c++) begin
                            if (!latched[c] && p_cmp[c]) begin
                                words[c]   <= p_dRamp;
                                latched[c] <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!sel_seen && sel_nonzero) overrun <= 1'b1;
                    if (out_if.out_ready) begin
                        if (out_if.out_col == LAST_COL) begin
                            out_if.out_valid <= 1'b0;
                            state            <= IDLE;
                            if (row_idx == LAST_ROW) frame_done <= 1'b1;
                        end else begin
                            out_if.out_col  <= out_if.out_col + COL_ONE;
                            out_if.out_data <= words[out_if.out_col + COL_ONE];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_readout.sv
// Randomized bench for pixel_readout, checked against a first-trip-wins row model.
module tb_pixel_readout;
    logic       clk;
    logic       reset;
    logic [3:0] p_row_select;
    logic [7:0] p_dRamp;
    logic [3:0] p_cmp;
    logic       frame_done;
    logic       overrun;

    int total;
    int bad;
    int exp_words[4];
    int got_data[$];
    int got_row[$];
    int got_col[$];

    pixel_readout_if #(.PIXEL_ARRAY_WIDTH(4), .PIXEL_ARRAY_HEIGHT(4)) bus ();

    pixel_readout #(.PIXEL_ARRAY_WIDTH(4), .PIXEL_ARRAY_HEIGHT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .p_row_select (p_row_select),
        .p_dRamp      (p_dRamp),
        .p_cmp        (p_cmp),
        .out_if       (bus),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records a word if this cycle's handshake completes, then steps past the next edge.
    task automatic cycle();
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_data.push_back(int'(bus.out_data));
            got_row.push_back(int'(bus.out_row));
            got_col.push_back(int'(bus.out_col));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_data.delete();
        got_row.delete();
        got_col.delete();
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // kind 0: random ramp and sparse random trips; 1: staggered trips on a 0..255 ramp;
    // 2: column 0 glitches high at 50, low, high again at 90.
    task automatic convert_row(input int row, input int n, input int kind);
        bit         tripped[4];
        logic [7:0] ramp;
        logic [3:0] cmp;
        for (int c = 0; c < 4; c++) begin
            exp_words[c] = 255;
            tripped[c]   = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            ramp = 8'($urandom_range(0, 255));
            for (int c = 0; c < 4; c++) cmp[c] = ($urandom_range(0, 7) == 0);
            if (kind == 1) begin
                ramp = 8'(i);
                cmp  = {1'b1, 1'b0, (i >= 200) ? 1'b1 : 1'b0, (i >= 10) ? 1'b1 : 1'b0};
            end else if (kind == 2) begin
                ramp   = 8'(i);
                cmp[0] = ((i >= 50 && i < 60) || i >= 90);
            end
            p_row_select = 4'(1 << row);
            p_dRamp      = ramp;
            p_cmp        = cmp;
            for (int c = 0; c < 4; c++) begin
                if (!tripped[c] && cmp[c]) begin
                    tripped[c]   = 1'b1;
                    exp_words[c] = int'(ramp);
                end
            end
            cycle();
        end
        p_row_select = 4'b0000;
        p_dRamp      = 8'($urandom_range(0, 255));
        p_cmp        = 4'($urandom_range(0, 15));
        cycle();
    endtask

    task automatic drain(input int target, input bit random_ready);
        int n = 0;
        while (got_data.size() < target && n < 300) begin
            bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        p_row_select = 4'b0000;
        p_dRamp = 8'h00;
        p_cmp = 4'b0000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", bus.out_data); end
        total++; if (bus.out_row !== 2'd0) begin bad++; $display("[TB] FAIL reset_row got=%0d want=0", bus.out_row); end
        total++; if (bus.out_col !== 2'd0) begin bad++; $display("[TB] FAIL reset_col got=%0d want=0", bus.out_col); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b want=0", overrun); end
        reset = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_staggered();
        int want[4] = '{10, 200, 255, 0};
        clear_got();
        convert_row(2, 256, 1);
        drain(4, 1'b0);
        total++; if (got_data.size() != 4) begin bad++; $display("[TB] FAIL stag_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++; if (got_data[i] != want[i]) begin bad++; $display("[TB] FAIL stag_data col%0d got=%0d want=%0d", i, got_data[i], want[i]); end
            total++; if (got_row[i] != 2 || got_col[i] != i) begin bad++; $display("[TB] FAIL stag_index got=r%0d c%0d want=r2 c%0d", got_row[i], got_col[i], i); end
        end
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL stag_frame_done got=%b want=0", frame_done); end
    endtask

    task automatic test_full_frame();
        int exp_all[$];
        clear_got();
        for (int r = 0; r < 4; r++) begin
            convert_row(r, $urandom_range(3, 20), 0);
            for (int c = 0; c < 4; c++) exp_all.push_back(exp_words[c]);
            drain(4 * (r + 1), 1'b1);
            if (r < 3) begin
                total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL frame_early_done row%0d got=%b want=0", r, frame_done); end
            end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL frame_done_pulse got=%b want=1", frame_done); end
        cycle();
        total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL frame_done_width got=%b want=0", frame_done); end
        total++; if (got_data.size() != 16) begin bad++; $display("[TB] FAIL frame_count got=%0d want=16", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            total++; if (got_data[i] != exp_all[i] || got_row[i] != i / 4 || got_col[i] != i % 4) begin
                bad++;
                $display("[TB] FAIL frame_word%0d got=%0d r%0d c%0d want=%0d r%0d c%0d", i, got_data[i], got_row[i], got_col[i], exp_all[i], i / 4, i % 4);
            end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL frame_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_data;
        clear_got();
        convert_row(1, 12, 0);
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        held_data = bus.out_data;
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++; if (bus.out_valid !== 1'b1 || bus.out_col !== 2'd1 || bus.out_data !== held_data) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d got=v%b c%0d d%h want=v1 c1 d%h", k, bus.out_valid, bus.out_col, bus.out_data, held_data);
            end
        end
        drain(4, 1'b0);
        total++; if (got_data.size() != 4) begin bad++; $display("[TB] FAIL bp_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++; if (got_data[i] != exp_words[i] || got_col[i] != i) begin bad++; $display("[TB] FAIL bp_word%0d got=%0d c%0d want=%0d c%0d", i, got_data[i], got_col[i], exp_words[i], i); end
        end
    endtask

    task automatic test_overrun();
        clear_got();
        convert_row(1, 8, 0);
        p_row_select  = 4'b1000;
        bus.out_ready = 1'b1;
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_before got=%b want=0", overrun); end
        cycle();
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_rise got=%b want=1", overrun); end
        drain(4, 1'b0);
        total++; if (got_data.size() != 4) begin bad++; $display("[TB] FAIL ovr_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++; if (got_data[i] != exp_words[i] || got_row[i] != 1) begin bad++; $display("[TB] FAIL ovr_word%0d got=%0d r%0d want=%0d r1", i, got_data[i], got_row[i], exp_words[i]); end
        end
        repeat (5) cycle();
        p_row_select = 4'b0000;
        repeat (3) cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_held_started got=%b want=0", bus.out_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky got=%b want=1", overrun); end
        pulse_reset();
    endtask

    task automatic test_glitch();
        clear_got();
        convert_row(0, 120, 2);
        drain(4, 1'b1);
        total++; if (got_data.size() != 4) begin bad++; $display("[TB] FAIL glitch_count got=%0d want=4", got_data.size()); end
        if (got_data.size() > 0) begin
            total++; if (got_data[0] != 50) begin bad++; $display("[TB] FAIL glitch_word got=%0d want=50", got_data[0]); end
        end
        for (int i = 1; i < got_data.size() && i < 4; i++) begin
            total++; if (got_data[i] != exp_words[i]) begin bad++; $display("[TB] FAIL glitch_word%0d got=%0d want=%0d", i, got_data[i], exp_words[i]); end
        end
        cycle();
        p_row_select = 4'b0110;
        cycle();
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL glitch_multi_sel_ovr got=%b want=1", overrun); end
        p_row_select = 4'b0000;
        repeat (3) cycle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL glitch_multi_sel_idle got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_drain();
        int row;
        p_row_select = 4'b0101;
        cycle();
        p_row_select = 4'b0000;
        cycle();
        convert_row(2, 10, 0);
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        #2 reset = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_data !== 8'h00 || bus.out_row !== 2'd0 || bus.out_col !== 2'd0) begin
            bad++;
            $display("[TB] FAIL rst_mid_outputs got=d%h r%0d c%0d want=d00 r0 c0", bus.out_data, bus.out_row, bus.out_col);
        end
        total++; if (overrun !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_flags got=o%b f%b want=o0 f0", overrun, frame_done); end
        bus.out_ready = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        clear_got();
        row = $urandom_range(0, 3);
        convert_row(row, 15, 0);
        drain(4, 1'b1);
        total++; if (got_data.size() != 4) begin bad++; $display("[TB] FAIL rst_next_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++; if (got_data[i] != exp_words[i] || got_row[i] != row || got_col[i] != i) begin
                bad++;
                $display("[TB] FAIL rst_next_word%0d got=%0d r%0d c%0d want=%0d r%0d c%0d", i, got_data[i], got_row[i], got_col[i], exp_words[i], row, i);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_staggered();
        test_full_frame();
        test_backpressure();
        test_overrun();
        test_glitch();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
